// File: rtl/mdu_div_unit_pkg.sv
// Shared definitions for the MIPS DIV/DIVU multi-cycle divider:
// FSM state encodings, ready/start strobe levels and the HI/LO result width.
package mdu_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Width of the {HI, LO} result pair.
    localparam int DOUBLE_REG_W = 64;

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring-division iteration: trial-subtract the divisor from the
// top of the working register, then shift in the resulting quotient bit.
module mdu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   work_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] work_hi_o,
    output logic                qbit_o
);

    logic signed [DATA_W:0] diff;

    // Trial subtraction; keep the difference only when it did not go negative.
    always_comb begin
        diff   = $signed(work_i[2*DATA_W:DATA_W]) - $signed({1'b0, divisor_i});
        qbit_o = (diff >= 0);
        if (diff < 0) begin
            work_hi_o = work_i[2*DATA_W-1:0];
        end else begin
            work_hi_o = {diff[DATA_W-1:0], work_i[DATA_W-1:0]};
        end
    end

endmodule

// File: rtl/mdu_div_unit.sv
// Multi-cycle radix-2 integer divider for MIPS DIV/DIVU. Produces
// {remainder, quotient} for the HI/LO registers, one quotient bit per cycle.
// Optional build macro MDU_DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// iteration is skipped and the result is produced with divide-by-zero latency.
module mdu_div_unit
    import mdu_div_unit_pkg::*;
#(
    parameter int DATA_W = DOUBLE_REG_W / 2,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_t state, next_state;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   dividend_r;
    logic [DATA_W-1:0]   divisor_r;
    logic                sign1_r, sign2_r;

    logic [2*DATA_W-1:0] step_hi;
    logic                step_qbit;
    logic [DATA_W-1:0]   abs1, abs2;
    logic                divisor_zero, cnt_done, early_out;
    logic                do_load, do_zero, do_iter, do_finish;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic use_sign);
        return (use_sign && v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic neg);
        logic signed [DATA_W-1:0] s;
        s = $signed(mag);
        return neg ? $unsigned(-s) : mag;
    endfunction

    assign abs1         = magnitude($signed(opdata1_i), signed_div_i);
    assign abs2         = magnitude($signed(opdata2_i), signed_div_i);
    assign divisor_zero = (opdata2_i == '0);
    assign cnt_done     = (cnt == CNT_W'(DATA_W));

`ifdef MDU_DIV_EARLY_OUT_EN
    assign early_out = (abs1 < abs2);
`else
    assign early_out = 1'b0;
`endif

    mdu_div_step #(.DATA_W(DATA_W)) u_step (
        .work_i    (dividend_r),
        .divisor_i (divisor_r),
        .work_hi_o (step_hi),
        .qbit_o    (step_qbit)
    );

    // State register; reset may abort a divide from any state.
    always_ff @(posedge clk) begin
        if (!reset) state <= DIV_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; annul always wins over progress.
    always_comb begin
        next_state = state;
        unique case (state)
            DIV_IDLE: begin
                if (start_i == DivStart && !annul_i)
                    next_state = divisor_zero ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: next_state = annul_i ? DIV_IDLE : DIV_END;
            DIV_ON: begin
                if (annul_i)       next_state = DIV_IDLE;
                else if (cnt_done) next_state = DIV_END;
            end
            DIV_END: begin
                if (annul_i || start_i == DivStop) next_state = DIV_IDLE;
            end
            default: next_state = DIV_IDLE;
        endcase
    end

    // Datapath strobes and the combinational stall request.
    always_comb begin
        busy_o    = start_i & ~ready_o;
        do_load   = (state == DIV_IDLE) && start_i && !annul_i && !divisor_zero;
        do_zero   = (state == DIV_BYZERO) && !annul_i;
        do_iter   = (state == DIV_ON) && !annul_i && !cnt_done;
        do_finish = (state == DIV_ON) && !annul_i && cnt_done;
    end

    // Control-side registers: counter, result bus and ready flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            ready_o <= (state == DIV_END && next_state == DIV_END) ?
                       DivResultReady : DivResultNotReady;
            // Early-out preloads the count so the next cycle finalises directly.
            if (do_load)      cnt <= early_out ? CNT_W'(DATA_W) : '0;
            else if (do_iter) cnt <= cnt + 1'b1;
            if (do_zero) begin
                result_o <= '0;
            end else if (do_finish) begin
                result_o <= {apply_sign(dividend_r[2*DATA_W:DATA_W+1], sign1_r),
                             apply_sign(dividend_r[DATA_W-1:0], sign1_r ^ sign2_r)};
            end
        end
    end

    // Working registers; operand magnitudes and signs captured at issue.
    always_ff @(posedge clk) begin
        if (do_load) begin
            divisor_r  <= abs2;
            sign1_r    <= signed_div_i & opdata1_i[DATA_W-1];
            sign2_r    <= signed_div_i & opdata2_i[DATA_W-1];
            // Early-out places the dividend straight in the remainder field.
            dividend_r <= early_out ? {abs1, {(DATA_W+1){1'b0}}}
                                    : {{DATA_W{1'b0}}, abs1, 1'b0};
        end else if (do_iter) begin
            dividend_r <= {step_hi, step_qbit};
        end
    end

endmodule

// File: tb/tb_mdu_div_unit.sv
// Self-checking bench for mdu_div_unit: fixed vector table, randomized divides
// against an arithmetic reference model, and annul/reset corner sequences.
module tb_mdu_div_unit;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MDU_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mdu_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [63:0] res;
    } vec_t;

    vec_t vecs [12];

    // MIPS semantics: truncating division, remainder takes dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic sg);
        logic [31:0] ma, mb;
        if (b == 32'd0) return 2;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        if (EARLY && ma < mb) return 2;
        return 34;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int cyc, output bit busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!ready_o && !busy_o) busy_ok = 1'b0;
        end while (!ready_o && cyc < 100);
    endtask

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [63:0] exp_res, input int exp_lat);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sg;
        start_i      = 1'b1;
        #1;
        check({name, " busy_issue"}, 64'(busy_o), 64'd1);
        wait_ready(cyc, busy_ok);
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " result"}, result_o, exp_res);
        check({name, " busy_until_ready"}, 64'(busy_ok), 64'd1);
        check({name, " busy_after_ready"}, 64'(busy_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, " ready_hold"}, 64'(ready_o), 64'd1);
        check({name, " result_hold"}, result_o, exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " ready_drop"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        logic        sg;
        logic [63:0] last_res;
        int          cyc;
        bit          busy_ok;
        bit          no_ready;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 64'h00000000_00000000};
        vecs[5]  = '{32'd9,          32'd3,          1'b0, 64'h00000000_00000003};
        vecs[6]  = '{32'd3,          32'd10,         1'b0, 64'h00000003_00000000};
        vecs[7]  = '{32'hDEADBEEF,   32'd1,          1'b0, 64'h00000000_DEADBEEF};
        vecs[8]  = '{32'hFFFFFFF6,   32'd3,          1'b1, 64'hFFFFFFFF_FFFFFFFD};
        vecs[9]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'h00000000_00000001};
        vecs[10] = '{32'hFFFFFFFD,   32'd10,         1'b1, 64'hFFFFFFFD_00000000};
        vecs[11] = '{32'hFFFFFFFF,   32'd2,          1'b0, 64'h00000001_7FFFFFFF};

        reset        = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].res,
                   ref_lat(vecs[i].a, vecs[i].b, vecs[i].sg));
        end
        last_res = vecs[11].res;

        // Annul mid-divide at cnt=10: no result, result bus untouched.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i  = 1'b0;
        no_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) no_ready = 1'b0;
        end
        check("annul no_ready", 64'(no_ready), 64'd1);
        check("annul result_kept", result_o, last_res);
        check("annul busy", 64'(busy_o), 64'd0);
        do_div("after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, ref_lat(9, 3, 0));

        // Reset at cnt=20 with start held; divide restarts after release.
        @(negedge clk);
        opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset result", result_o, 64'd0);
        check("midreset ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(cyc, busy_ok);
        check("restart latency", 64'(cyc), 64'd34);
        check("restart result", result_o, 64'h00000003_24924924);
        check("restart busy", 64'(busy_ok), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check("restart ready_drop", 64'(ready_o), 64'd0);

        // Randomized divides against the reference model.
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            a    = $urandom;
            b    = $urandom;
            sg   = 1'($urandom_range(0, 1));
            if (mode == 0)      b = 32'd0;
            else if (mode <= 2) b = $urandom_range(1, 15);
            else if (mode == 3) a = $urandom_range(0, 255);
            do_div($sformatf("rnd%0d", i), a, b, sg, ref_div(a, b, sg), ref_lat(a, b, sg));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
